encoder_led_ring: RTL
=====================

Name: encoder_led_ring

Overview:
Upstream producer of the 16-bit LED image for the mbi5124_shiftout serializer on the LED-Encoder breakout.
- Synchronizes and debounces the rotary encoder A/B quadrature lines and the push switch.
- Decodes detent steps into a saturating position, 0..LED_COUNT.
- Renders the position as a bar or dot pattern on leds[15:0], bit 0 = first LED in the chain.
- The push switch toggles the render mode.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive stable clk cycles required before a synchronized input is accepted; range 2..65535.
TRANS_PER_DETENT, 4, valid quadrature transitions in one direction per reported step; allowed values 1, 2, 4.
LED_COUNT, 16, number of LEDs; also the maximum position.

Ports:
clk  in  1  system clock.
rstn  in  1  asynchronous active-low reset.
enc_a  in  1  encoder channel A, asynchronous, raw.
enc_b  in  1  encoder channel B, asynchronous, raw.
enc_sw  in  1  encoder push switch, asynchronous, active-low, raw.
leds  out  16  LED image for the serializer; 1 = LED on.
pos  out  5  current position, 0..LED_COUNT.
mode  out  1  0 = bar, 1 = dot.
step_up  out  1  one-cycle pulse when pos increments.
step_dn  out  1  one-cycle pulse when pos decrements.
quad_err  out  1  one-cycle pulse on an illegal quadrature transition.

Behaviour:
- Reset (async assert, sync deassert inside the block): all outputs 0, pos = 0, mode = 0, leds = 16'h0000. Synchronizer and debounced registers load 1 (idle levels). Counters clear.
- Synchronizer: 2-FF chain on each of enc_a, enc_b, enc_sw.
- Debouncer, one per input:
  - The counter increments while the synchronized value differs from the debounced value, and clears when they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced value takes the new level and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES resets the count.
- Quadrature decoder:
  - Works on the debounced {a,b}; previous state is held in a register.
  - Forward sequence 00->01->11->10->00 gives +1. Reverse sequence gives -1.
  - No change: nothing.
  - Both bits changing in one cycle: quad_err pulses, the sub-counter clears, prev updates.
  - A signed sub-counter accumulates transitions. At +TRANS_PER_DETENT a step-up is requested; at -TRANS_PER_DETENT a step-down is requested. The sub-counter clears on either request.
  - A direction reversal mid-detent simply decrements the sub-counter; no step.
- Position:
  - Step-up with pos < LED_COUNT: pos+1, step_up pulses.
  - Step-up at LED_COUNT: saturate, no pulse.
  - Step-down is symmetric, saturating at 0.
  - Step pulses coincide with the pos update cycle.
- Mode: a debounced enc_sw falling edge (press) toggles mode. Hold and release have no effect.
- Render (registered, one cycle after pos/mode change):
  - Bar: leds[i] = (i < pos).
  - Dot: leds[i] = (i == pos-1); pos = 0 gives all off.
  - Bits at or above LED_COUNT are 0.
- Latency:
  - Raw edge to debounced value: 2 sync + DEBOUNCE_CYCLES cycles.
  - Debounced value to pos: 1 cycle.
  - pos to leds: 1 cycle.
- Simultaneous events:
  - A switch press and a step in the same cycle are both applied.
  - leds reflects the new pos and the new mode together on the next cycle.
- Reset mid-detent discards the partial sub-count.
- leds may change at any cycle. The serializer samples each bit during its frame; tearing across one frame is acceptable.

Decomposition:
- Shared package holds:
  - the LED_COUNT default;
  - the quadrature state encodings (Q00, Q01, Q11, Q10);
  - the mode encodings MODE_BAR = 0, MODE_DOT = 1.
- One natural sub-module: input_debounce (2-FF sync + stability counter, parameter DEBOUNCE_CYCLES, reset level 1). Instantiated three times.

Test Plan:
- Reset only, then idle 5000 cycles -> leds = 0, pos = 0, mode = 0, no pulses.
- DEBOUNCE_CYCLES = 8; one full forward detent (4 clean transitions spaced 20 cycles apart) -> exactly one step_up, pos = 1, leds = 16'h0001 one cycle after pos.
- 20 forward detents -> pos saturates at 16, leds = 16'hFFFF, exactly 16 step_up pulses. Then 3 reverse detents -> pos = 13, leds = 16'h1FFF.
- At pos = 5, press the switch (low for 50 cycles, then release) -> mode = 1, leds = 16'h0010. Press again -> leds = 16'h001F.
- Glitch on enc_a of 5 cycles (< 8) -> no debounced change, no pulses. Force {a,b} 00->11 in one step -> one quad_err, pos unchanged.
- Two forward transitions, reverse two, assert rstn low mid-sequence -> no step pulses, pos = 0. After release, a fresh full detent yields pos = 1.

Source files
------------

// File: rtl/encoder_led_ring_pkg.sv
// Purpose: shared constants and encodings for the encoder LED ring block.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package encoder_led_ring_pkg;

  localparam int LED_COUNT_DEF = 16;

  // Debounced {a,b} levels of the quadrature encoder.
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_t;

  typedef enum logic {
    MODE_BAR = 1'b0,
    MODE_DOT = 1'b1
  } mode_t;

  // Position of a quadrature state within the forward cycle
  // 00 -> 01 -> 11 -> 10 -> 00. The 2-bit wrapped difference of two phases
  // is 1 for a forward step, 3 for a reverse step, 2 for an illegal jump.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    logic [1:0] ph;
    ph = 2'd3;
    case (quad_t'(ab))
      Q00:     ph = 2'd0;
      Q01:     ph = 2'd1;
      Q11:     ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/encoder_led_ring_input_debounce.sv
// Purpose: 2-FF synchronizer plus stability counter for one raw, asynchronous input.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles from raw edge to dout.
// Backpressure: none; dout is a free-running level.
// Ports: clk, rstn (async active-low), din (raw input), dout (debounced level, resets to 1).
module input_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [1:0]  sync;
  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync <= 2'b11;
      dout <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], din};
      // Any return to the accepted level restarts the count, so a glitch
      // shorter than DEBOUNCE_CYCLES never propagates.
      if (sync[1] == dout) begin
        cnt <= '0;
      end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync[1];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/encoder_led_ring.sv
// Purpose: debounced rotary encoder -> saturating position -> bar/dot LED image.
// Latency: raw edge +2+DEBOUNCE_CYCLES to debounced, +1 to pos/pulses, +1 to leds.
// Backpressure: none; leds may change any cycle, the serializer tolerates tearing.
// Ports: clk, rstn (async active-low); enc_a/enc_b/enc_sw raw inputs (enc_sw active-low);
//        leds[15:0] image, pos[4:0], mode (0 bar, 1 dot), step_up/step_dn/quad_err pulses.
module encoder_led_ring
  import encoder_led_ring_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1000,
  parameter int TRANS_PER_DETENT = 4,
  parameter int LED_COUNT        = LED_COUNT_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic        enc_sw,
  output logic [15:0] leds,
  output logic [4:0]  pos,
  output logic        mode,
  output logic        step_up,
  output logic        step_dn,
  output logic        quad_err
);

  localparam logic signed [3:0] TPD_POS = 4'(TRANS_PER_DETENT);
  localparam logic signed [3:0] TPD_NEG = -TPD_POS;

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_pipe;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rst_pipe <= 2'b00;
    else       rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_int_n = rst_pipe[1];

  logic a_deb, b_deb, sw_deb;

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .rstn(rst_int_n), .din(enc_a), .dout(a_deb)
  );
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .rstn(rst_int_n), .din(enc_b), .dout(b_deb)
  );
  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_sw (
    .clk(clk), .rstn(rst_int_n), .din(enc_sw), .dout(sw_deb)
  );

  logic [1:0]        ab_cur, ab_prev, phase_diff;
  logic signed [3:0] sub, sub_nxt;
  logic              req_up, req_dn, err_nxt, sw_prev, press;
  logic [15:0]       leds_nxt;

  assign ab_cur     = {a_deb, b_deb};
  assign phase_diff = quad_phase(ab_cur) - quad_phase(ab_prev);
  assign press      = sw_prev & ~sw_deb;

  always_comb begin
    sub_nxt = sub;
    req_up  = 1'b0;
    req_dn  = 1'b0;
    err_nxt = 1'b0;
    case (phase_diff)
      2'd1: sub_nxt = sub + 4'sd1;
      2'd3: sub_nxt = sub - 4'sd1;
      2'd2: begin
        err_nxt = 1'b1;
        sub_nxt = '0;
      end
      default: ;
    endcase
    if (sub_nxt == TPD_POS) begin
      req_up  = 1'b1;
      sub_nxt = '0;
    end else if (sub_nxt == TPD_NEG) begin
      req_dn  = 1'b1;
      sub_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ab_prev  <= Q11;
      sub      <= '0;
      sw_prev  <= 1'b1;
      pos      <= '0;
      mode     <= MODE_BAR;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      quad_err <= 1'b0;
    end else begin
      ab_prev  <= ab_cur;
      sub      <= sub_nxt;
      sw_prev  <= sw_deb;
      quad_err <= err_nxt;
      step_up  <= 1'b0;
      step_dn  <= 1'b0;
      if (req_up && pos < 5'(LED_COUNT)) begin
        pos     <= pos + 5'd1;
        step_up <= 1'b1;
      end else if (req_dn && pos != 5'd0) begin
        pos     <= pos - 5'd1;
        step_dn <= 1'b1;
      end
      if (press) mode <= ~mode;
    end
  end

  always_comb begin
    leds_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < LED_COUNT) begin
        if (mode == MODE_BAR) leds_nxt[i] = (5'(i) < pos);
        else                  leds_nxt[i] = (pos != 5'd0) && (5'(i) == pos - 5'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) leds <= '0;
    else            leds <= leds_nxt;
  end

endmodule
